// File: rtl/digit_scan_ctrl_pkg.sv
// Shared display definitions for the multiplexed 4-digit BCD scan controller.
// Provides the digit count, the largest legal BCD code, the digit-index type
// and a helper that checks a packed 4-nibble word for legal BCD digits.
package display_pkg;

   localparam int         NUM_DIGITS = 4;
   localparam logic [3:0] BCD_MAX    = 4'd9;

   typedef logic [1:0] digit_idx_t;

   // True when every nibble of the word is a legal BCD digit.
   function automatic logic bcd_word_ok(input logic [15:0] word);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (word[4*i +: 4] > BCD_MAX) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Load/display bundle of the digit scan controller.
//   load_valid/load_data/load_ready : 4-digit BCD load handshake
//   bcd_out                         : BCD code of the active digit
//   digit_en                        : one-hot digit select (all-zero when blanked)
//   frame_done                      : one-cycle pulse on the 3->0 scan wrap
//   load_err                        : one-cycle pulse when an offered load is rejected
// master = load source / display consumer, slave = controller.
interface digit_scan_if;

   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;
   logic [3:0]  bcd_out;
   logic [3:0]  digit_en;
   logic        frame_done;
   logic        load_err;

   modport master (
      output load_valid, load_data,
      input  load_ready, bcd_out, digit_en, frame_done, load_err
   );

   modport slave (
      input  load_valid, load_data,
      output load_ready, bcd_out, digit_en, frame_done, load_err
   );

endinterface

// File: rtl/digit_scan_ctrl_prescaler.sv
// scan_prescaler: divides clk down to the digit-slot rate.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : high for the one cycle per slot where count == CLK_DIV-1
// CLK_DIV legal range 2..2^20.
module scan_prescaler #(
   parameter int unsigned CLK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int unsigned   CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   assign tick = (count == TC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    count <= '0;
      else if (tick) count <= '0;
      else           count <= count + CW'(1);
   end

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed 4-digit BCD display scanner with a tear-free
// double-buffered load path.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : digit_scan_if.slave (load handshake, bcd_out, digit_en,
//                frame_done, load_err)
// Optional build macro DIGIT_SCAN_LZB_EN compiles in leading-zero blanking.
//
//   idx | meaning
//   ----+-----------------------------------------------
//    0  | slot for digit 0 (rightmost), never blanked
//    1  | slot for digit 1
//    2  | slot for digit 2
//    3  | slot for digit 3; tick here wraps and commits
module digit_scan_ctrl
   import display_pkg::*;
#(
   parameter int unsigned CLK_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   digit_scan_if.slave bus
);

   logic        tick;
   digit_idx_t  idx, idx_nxt;
   logic [15:0] active, active_nxt;
   logic [15:0] pending, pending_nxt;
   logic        pending_full, pending_full_nxt;
   logic        frame_done_q, frame_done_nxt;
   logic        load_err_q, load_err_nxt;
   logic        wrap;
   logic        handshake;
   logic        load_ok;
   logic [3:0]  onehot;

   scan_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign wrap      = tick && (idx == digit_idx_t'(NUM_DIGITS - 1));
   // load_ready is low whenever a commit is possible, so a new handshake can
   // never land on the commit edge.
   assign handshake = bus.load_valid && !pending_full;
   assign load_ok   = bcd_word_ok(bus.load_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx          <= '0;
         active       <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
         frame_done_q <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         idx          <= idx_nxt;
         active       <= active_nxt;
         pending      <= pending_nxt;
         pending_full <= pending_full_nxt;
         frame_done_q <= frame_done_nxt;
         load_err_q   <= load_err_nxt;
      end
   end

   always_comb begin
      idx_nxt          = idx;
      active_nxt       = active;
      pending_nxt      = pending;
      pending_full_nxt = pending_full;
      frame_done_nxt   = wrap;
      load_err_nxt     = handshake && !load_ok;

      if (tick) idx_nxt = idx + 2'd1;

      if (wrap && pending_full) begin
         active_nxt       = pending;
         pending_full_nxt = 1'b0;
      end

      if (handshake && load_ok) begin
         pending_nxt      = bus.load_data;
         pending_full_nxt = 1'b1;
      end
   end

   assign onehot         = 4'b0001 << idx;
   assign bus.bcd_out    = active[{idx, 2'b00} +: 4];
   assign bus.load_ready = !pending_full;
   assign bus.frame_done = frame_done_q;
   assign bus.load_err   = load_err_q;

`ifdef DIGIT_SCAN_LZB_EN
   logic blank;

   // A slot goes dark when its digit and every digit to its left are zero.
   always_comb begin
      blank = 1'b0;
      case (idx)
         2'd1:    blank = (active[15:4]  == 12'h000);
         2'd2:    blank = (active[15:8]  == 8'h00);
         2'd3:    blank = (active[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
   end

   assign bus.digit_en = blank ? 4'b0000 : onehot;
`else
   assign bus.digit_en = onehot;
`endif

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl with CLK_DIV=4 (16-cycle frames).
// Expected slot contents are queued when a load is offered and popped as the
// DUT scans each frame.
module tb_digit_scan_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   digit_scan_if bus();

   digit_scan_ctrl #(.CLK_DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] en;
      logic [3:0] bcd;
   } slot_t;

   slot_t exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] exp_en(input logic [15:0] v, input int i);
      logic [3:0] oh;
      oh = 4'b0001 << i;
`ifdef DIGIT_SCAN_LZB_EN
      if (i > 0 && (v >> (4*i)) == 16'h0000) oh = 4'b0000;
`endif
      return oh;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [15:0] v);
      slot_t s;
      for (int i = 0; i < 4; i++) begin
         s.en  = exp_en(v, i);
         s.bcd = v[4*i +: 4];
         exp_q.push_back(s);
      end
   endtask

   // Waits for frame_done, then checks all four slots at their first and
   // last cycle and that the next frame_done falls exactly 16 cycles later.
   task automatic check_frame();
      slot_t e;
      int    n;
      n = 0;
      while (bus.frame_done !== 1'b1 && n < 64) begin
         step();
         n++;
      end
      if (n >= 64) begin
         chk("frame_wait_timeout", 16'h0, 16'h1);
         return;
      end
      for (int s = 0; s < 4; s++) begin
         if (exp_q.size() == 0) begin
            chk("queue_empty", 16'h0, 16'h1);
            return;
         end
         e = exp_q.pop_front();
         for (int c = 0; c < 4; c++) begin
            if (c == 0 || c == 3) begin
               chk("slot_en",  16'(bus.digit_en), 16'(e.en));
               chk("slot_bcd", 16'(bus.bcd_out),  16'(e.bcd));
            end
            if (c == 2) chk("frame_done_mid", 16'(bus.frame_done), 16'h0);
            step();
         end
      end
      chk("frame_period", 16'(bus.frame_done), 16'h1);
   endtask

   // Holds load_valid with d until load_ready is seen, steps through the
   // handshake edge and releases. n = cycles spent waiting for load_ready.
   task automatic offer(input logic [15:0] d, output logic err, output int n);
      err = 1'b0;
      n   = 0;
      bus.load_data  = d;
      bus.load_valid = 1'b1;
      while (bus.load_ready !== 1'b1 && n < 64) begin
         step();
         n++;
      end
      if (n >= 64) begin
         chk("offer_timeout", 16'h0, 16'h1);
         bus.load_valid = 1'b0;
         return;
      end
      step();
      err = bus.load_err;
      bus.load_valid = 1'b0;
   endtask

   // Asserts reset off the clock edge, checks the reset outputs at once, then
   // releases and checks that the first slot advance comes on edge 4.
   task automatic do_reset();
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_digit_en",   16'(bus.digit_en),   16'h1);
      chk("rst_bcd",        16'(bus.bcd_out),    16'h0);
      chk("rst_ready",      16'(bus.load_ready), 16'h1);
      chk("rst_frame_done", 16'(bus.frame_done), 16'h0);
      chk("rst_load_err",   16'(bus.load_err),   16'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         step();
         if (e == 3) chk("tick_not_early", 16'(bus.digit_en), 16'h1);
         if (e == 4) chk("first_tick",     16'(bus.digit_en), 16'(exp_en(16'h0000, 1)));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic err;
      int   n;
      int   n2;
      rst_n          = 1'b1;
      bus.load_valid = 1'b0;
      bus.load_data  = 16'h0000;

      do_reset();

      // Basic load and scan order.
      push_frame(16'h1234);
      offer(16'h1234, err, n);
      chk("load1234_err", 16'(err), 16'h0);
      check_frame();

      // Back-pressure: second load waits for the commit of the first.
      offer(16'h5678, err, n);
      chk("load5678_wait", 16'(n), 16'h0);
      push_frame(16'h5678);
      push_frame(16'h9999);
      chk("ready_low_pending", 16'(bus.load_ready), 16'h0);
      fork
         offer(16'h9999, err, n2);
         begin
            check_frame();
            check_frame();
         end
      join
      chk("ready_wait_cycles", 16'(n2), 16'd15);

      // Illegal BCD nibble is rejected with a single error pulse.
      offer(16'h12A4, err, n);
      chk("reject_wait",  16'(n),   16'h0);
      chk("reject_err",   16'(err), 16'h1);
      chk("reject_ready", 16'(bus.load_ready), 16'h1);
      step();
      chk("reject_err_pulse", 16'(bus.load_err),   16'h0);
      chk("reject_ready2",    16'(bus.load_ready), 16'h1);
      push_frame(16'h9999);
      check_frame();

      // Leading-zero patterns.
      offer(16'h0045, err, n);
      push_frame(16'h0045);
      check_frame();
      offer(16'h0000, err, n);
      push_frame(16'h0000);
      check_frame();

      // Reset mid-frame with a load pending: pending is discarded.
      offer(16'h1111, err, n);
      chk("pend_ready_low", 16'(bus.load_ready), 16'h0);
      repeat (5) step();
      do_reset();
      chk("post_rst_ready", 16'(bus.load_ready), 16'h1);
      push_frame(16'h0000);
      check_frame();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
